// File: rtl/jtpinpon_objscan.sv
// jtpinpon_objscan: per-line object scheduler.
// Restarts on every line-start pulse, reads each object's 4 attribute bytes
// in index order, tests Y against the line being rendered and hands each hit
// to the line drawer with a draw/busy handshake.
//
// Ports:
//   clk_i, rst_i      system clock, synchronous active-high reset
//   cen2_i            clock enable shared with the drawer
//   hinit_x_i         line-start pulse (acts on any clk edge)
//   vdump_i           current video line
//   obj_addr_o        object RAM byte address {index, byte}
//   obj_dout_i        object RAM data, valid one clk after obj_addr_o
//   draw_o, busy_i    drawer handshake
//   xpos_o, ysub_o, pal_o, hflip_o, vflip_o, code_o   fields for the drawer
//   done_o            scan for the current line finished
//
// state  | meaning
// IDLE   | scan finished, waiting for the next line start
// RD0    | put byte0 (Y) address out
// RD1    | capture Y, address byte1
// RD2    | capture code, address byte2
// RD3    | capture flips/palette, address byte3
// RD4    | capture X
// CHECK  | Y compare, load drawer fields on a hit
// REQ    | wait for drawer idle, then pulse draw
// WAIT   | wait for the drawer to finish the object
// NEXT   | advance index or end the scan
module jtpinpon_objscan #(
  parameter int         OBJ_AW  = 6,
  parameter int         MAXOBJ  = 24,
  parameter logic [7:0] VOFFSET = 8'd1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cen2_i,
  input  logic              hinit_x_i,
  input  logic [7:0]        vdump_i,
  output logic [OBJ_AW+1:0] obj_addr_o,
  input  logic [7:0]        obj_dout_i,
  output logic              draw_o,
  input  logic              busy_i,
  output logic [7:0]        xpos_o,
  output logic [3:0]        ysub_o,
  output logic [4:0]        pal_o,
  output logic              hflip_o,
  output logic              vflip_o,
  output logic [7:0]        code_o,
  output logic              done_o
);

  localparam int CW = $clog2(MAXOBJ + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_CHECK, S_REQ, S_WAIT, S_NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [OBJ_AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          vrender_q, vrender_d;
  logic [7:0]          y_q, y_d;
  logic [7:0]          tcode_q, tcode_d;
  logic [7:0]          tattr_q, tattr_d;
  logic [7:0]          tx_q, tx_d;
  logic [OBJ_AW+1:0]   addr_q, addr_d;
  logic                draw_q, draw_d;
  logic                done_q, done_d;
  logic [7:0]          xpos_q, xpos_d;
  logic [3:0]          ysub_q, ysub_d;
  logic [4:0]          pal_q, pal_d;
  logic                hflip_q, hflip_d;
  logic                vflip_q, vflip_d;
  logic [7:0]          code_q, code_d;

  logic [7:0] ydiff;
  logic       hit;
  logic       last_idx;
  logic       cnt_full;
  logic       wait_over;

  assign ydiff    = vrender_q - y_q;
  // Y==0 marks an unused slot
  assign hit      = (ydiff[7:4] == 4'd0) && (y_q != 8'd0);
  assign last_idx = &idx_q;
  assign cnt_full = (cnt_q == CW'(MAXOBJ));
  // busy from the drawer only becomes visible one cen2 period after it
  // sampled draw, so the first WAIT period (draw still high) never exits.
  assign wait_over = !draw_q && !busy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      vrender_q <= '0;
      y_q       <= '0;
      tcode_q   <= '0;
      tattr_q   <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      draw_q    <= 1'b0;
      done_q    <= 1'b1;
      xpos_q    <= '0;
      ysub_q    <= '0;
      pal_q     <= '0;
      hflip_q   <= 1'b0;
      vflip_q   <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      vrender_q <= vrender_d;
      y_q       <= y_d;
      tcode_q   <= tcode_d;
      tattr_q   <= tattr_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      draw_q    <= draw_d;
      done_q    <= done_d;
      xpos_q    <= xpos_d;
      ysub_q    <= ysub_d;
      pal_q     <= pal_d;
      hflip_q   <= hflip_d;
      vflip_q   <= vflip_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (hinit_x_i) begin
      state_d = S_RD0;
    end else if (cen2_i) begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RD0:   state_d = S_RD1;
        S_RD1:   state_d = S_RD2;
        S_RD2:   state_d = S_RD3;
        S_RD3:   state_d = S_RD4;
        S_RD4:   state_d = S_CHECK;
        S_CHECK: state_d = hit ? S_REQ : S_NEXT;
        S_REQ:   if (!busy_i) state_d = S_WAIT;
        S_WAIT:  if (wait_over) state_d = S_NEXT;
        S_NEXT:  state_d = (last_idx || cnt_full) ? S_IDLE : S_RD0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    vrender_d = vrender_q;
    y_d       = y_q;
    tcode_d   = tcode_q;
    tattr_d   = tattr_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    draw_d    = draw_q;
    done_d    = done_q;
    xpos_d    = xpos_q;
    ysub_d    = ysub_q;
    pal_d     = pal_q;
    hflip_d   = hflip_q;
    vflip_d   = vflip_q;
    code_d    = code_q;
    if (hinit_x_i) begin
      vrender_d = vdump_i + VOFFSET;
      idx_d     = '0;
      cnt_d     = '0;
      draw_d    = 1'b0;
      done_d    = 1'b0;
    end else if (cen2_i) begin
      case (state_q)
        S_IDLE: done_d = 1'b1;
        S_RD0:  addr_d = {idx_q, 2'd0};
        S_RD1: begin
          y_d    = obj_dout_i;
          addr_d = {idx_q, 2'd1};
        end
        S_RD2: begin
          tcode_d = obj_dout_i;
          addr_d  = {idx_q, 2'd2};
        end
        S_RD3: begin
          tattr_d = obj_dout_i;
          addr_d  = {idx_q, 2'd3};
        end
        S_RD4: tx_d = obj_dout_i;
        S_CHECK: begin
          // fields only change on a hit so they stay valid through draw
          if (hit) begin
            xpos_d  = tx_q;
            ysub_d  = ydiff[3:0];
            pal_d   = tattr_q[4:0];
            hflip_d = tattr_q[7];
            vflip_d = tattr_q[6];
            code_d  = tcode_q;
          end
        end
        S_REQ: if (!busy_i) draw_d = 1'b1;
        S_WAIT: begin
          draw_d = 1'b0;
          if (wait_over) cnt_d = cnt_q + CW'(1);
        end
        S_NEXT: begin
          if (last_idx || cnt_full) done_d = 1'b1;
          else                      idx_d  = idx_q + OBJ_AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign obj_addr_o = addr_q;
  assign draw_o     = draw_q;
  assign done_o     = done_q;
  assign xpos_o     = xpos_q;
  assign ysub_o     = ysub_q;
  assign pal_o      = pal_q;
  assign hflip_o    = hflip_q;
  assign vflip_o    = vflip_q;
  assign code_o     = code_q;

endmodule

// File: tb/tb_jtpinpon_objscan.sv
// Directed bench for jtpinpon_objscan with an object RAM model and a
// drawer model that holds busy for a programmable number of cen2 periods.
module tb_jtpinpon_objscan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cen2 = 1'b0;
  logic       hinit = 1'b0;
  logic [7:0] vdump = 8'd0;
  logic [7:0] obj_addr;
  logic [7:0] obj_dout = 8'd0;
  logic       draw;
  logic       busy = 1'b0;
  logic [7:0] xpos;
  logic [3:0] ysub;
  logic [4:0] pal;
  logic       hflip, vflip;
  logic [7:0] code;
  logic       done;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:255];

  // drawer model state
  int         busy_len = 3;
  logic       log_clr = 1'b0;
  int         bcnt = 0;
  int         edge_n = 0;
  int         ndraw = 0;
  int         nfall = 0;
  int         busy_viol = 0;
  int         pulse_viol = 0;
  logic       prev_draw = 1'b0;
  int         draw_t [0:63];
  int         fall_t [0:63];
  logic [7:0] log_code [0:63];
  logic [3:0] log_ysub [0:63];

  jtpinpon_objscan dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cen2_i     (cen2),
    .hinit_x_i  (hinit),
    .vdump_i    (vdump),
    .obj_addr_o (obj_addr),
    .obj_dout_i (obj_dout),
    .draw_o     (draw),
    .busy_i     (busy),
    .xpos_o     (xpos),
    .ysub_o     (ysub),
    .pal_o      (pal),
    .hflip_o    (hflip),
    .vflip_o    (vflip),
    .code_o     (code),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // cen2 is high on every other rising edge
  always @(negedge clk) cen2 = ~cen2;

  always @(posedge clk) obj_dout <= mem[obj_addr];

  always @(posedge clk) begin
    if (log_clr) begin
      ndraw      <= 0;
      nfall      <= 0;
      busy_viol  <= 0;
      pulse_viol <= 0;
    end else if (cen2) begin
      edge_n    <= edge_n + 1;
      prev_draw <= draw;
      if (draw) begin
        if (busy)      busy_viol  <= busy_viol + 1;
        if (prev_draw) pulse_viol <= pulse_viol + 1;
        if (ndraw < 64) begin
          draw_t[ndraw]   <= edge_n;
          log_code[ndraw] <= code;
          log_ysub[ndraw] <= ysub;
        end
        ndraw <= ndraw + 1;
        busy  <= 1'b1;
        bcnt  <= busy_len;
      end else if (bcnt > 1) begin
        bcnt <= bcnt - 1;
      end else if (bcnt == 1) begin
        bcnt <= 0;
        busy <= 1'b0;
        if (nfall < 64) fall_t[nfall] <= edge_n;
        nfall <= nfall + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
  endtask

  task automatic set_obj(input int idx, input logic [7:0] y, input logic [7:0] c,
                         input logic [7:0] b2, input logic [7:0] x);
    mem[idx*4]   = y;
    mem[idx*4+1] = c;
    mem[idx*4+2] = b2;
    mem[idx*4+3] = x;
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
  endtask

  task automatic start_line(input logic [7:0] v);
    vdump = v;
    hinit = 1'b1;
    tick();
    hinit = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20000) begin
      tick();
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 2000) begin
      tick();
      n++;
    end
    check(tag, busy, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, obj_addr, 0);
    check({tag, "_draw"}, draw, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_xpos"}, xpos, 0);
    check({tag, "_ysub"}, ysub, 0);
    check({tag, "_pal"}, pal, 0);
    check({tag, "_code"}, code, 0);
    check({tag, "_hflip"}, hflip, 0);
    check({tag, "_vflip"}, vflip, 0);
  endtask

  initial begin
    int ord_err;
    int n;
    clear_mem();

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("rst");

    // 1: single hit at index 0, vrender=0x45, ydiff=5
    set_obj(0, 8'h40, 8'h12, 8'hC5, 8'h30);
    busy_len = 3;
    clear_log();
    start_line(8'h44);
    check("t1_done_low", done, 0);
    wait_done("t1_done");
    check("t1_ndraw", ndraw, 1);
    check("t1_xpos", xpos, 8'h30);
    check("t1_ysub", ysub, 4'd5);
    check("t1_pal", pal, 5'd5);
    check("t1_hflip", hflip, 1);
    check("t1_vflip", vflip, 1);
    check("t1_code", code, 8'h12);
    check("t1_log_code", log_code[0], 8'h12);
    check("t1_last_addr", obj_addr, 8'hFF);

    // 2: vrender=0x50, ydiff=16 -> miss; fields keep previous hit
    clear_log();
    start_line(8'h4F);
    wait_done("t2_done");
    check("t2_ndraw", ndraw, 0);
    check("t2_last_addr", obj_addr, 8'hFF);
    check("t2_xpos_hold", xpos, 8'h30);

    // 3a: Y=0 everywhere, vrender=0 would otherwise match
    clear_mem();
    for (int i = 0; i < 64; i++) set_obj(i, 8'h00, 8'h55, 8'h00, 8'h11);
    clear_log();
    start_line(8'hFF);
    wait_done("t3a_done");
    check("t3a_ndraw", ndraw, 0);

    // 3b: Y wrap, Y=0xF8 vrender=0x03 -> ysub=11
    clear_mem();
    set_obj(5, 8'hF8, 8'h77, 8'h1F, 8'h99);
    clear_log();
    start_line(8'h02);
    wait_done("t3b_done");
    check("t3b_ndraw", ndraw, 1);
    check("t3b_ysub", ysub, 4'd11);
    check("t3b_code", code, 8'h77);
    check("t3b_pal", pal, 5'h1F);
    check("t3b_hflip", hflip, 0);
    check("t3b_xpos", xpos, 8'h99);

    // 4: all 64 hit, only MAXOBJ drawn in index order
    clear_mem();
    for (int i = 0; i < 64; i++) set_obj(i, 8'h10, 8'(i), 8'hD3, 8'(8'h80 + i));
    clear_log();
    start_line(8'h12);
    wait_done("t4_done");
    check("t4_ndraw", ndraw, 24);
    ord_err = 0;
    for (int k = 0; k < 24; k++)
      if (log_code[k] !== 8'(k) || log_ysub[k] !== 4'd3) ord_err++;
    check("t4_order", ord_err, 0);
    check("t4_busy_viol", busy_viol, 0);
    check("t4_pulse_viol", pulse_viol, 0);
    check("t4_last_addr", obj_addr, 8'h5F);
    check("t4_xpos", xpos, 8'h97);

    // 5: long busy, second request only after busy falls
    clear_mem();
    set_obj(0, 8'h10, 8'hA0, 8'h00, 8'h01);
    set_obj(1, 8'h10, 8'hA1, 8'h00, 8'h02);
    busy_len = 40;
    clear_log();
    start_line(8'h12);
    wait_busy("t5_busy_rise");
    repeat (20) tick();
    check("t5_draw_in_wait", draw, 0);
    check("t5_busy_mid", busy, 1);
    check("t5_ndraw_mid", ndraw, 1);
    wait_done("t5_done");
    check("t5_ndraw", ndraw, 2);
    check("t5_after_fall", (draw_t[1] > fall_t[0]) ? 1 : 0, 1);
    check("t5_gap", (draw_t[1] - draw_t[0] >= 41) ? 1 : 0, 1);
    check("t5_busy_viol", busy_viol, 0);
    check("t5_pulse_viol", pulse_viol, 0);
    check("t5_code2", log_code[1], 8'hA1);

    // 6: line restart during WAIT, then reset mid-RD2 with cen2 low
    clear_mem();
    for (int i = 0; i < 64; i++) set_obj(i, 8'h10, 8'(i), 8'hD3, 8'(8'h80 + i));
    clear_log();
    start_line(8'h12);
    wait_busy("t6_busy_rise");
    start_line(8'h12);
    check("t6_done_low", done, 0);
    check("t6_draw_low", draw, 0);
    n = 0;
    while (obj_addr !== 8'h01 && n < 40) begin
      tick();
      n++;
    end
    check("t6_restart_addr", obj_addr, 8'h01);
    check("t6_done_scan", done, 0);
    check("t6_xpos_pre", xpos, 8'h80);
    if (cen2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("t6_rst");
    repeat (6) tick();
    check("t6_idle_addr", obj_addr, 0);
    check("t6_idle_done", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
